multiplier_control_taint_bitwise: RTL and testbench

//   Parametrised controller for the shift-add sequential multiplier with
//   bit-granular taint tracking. It sequences load/clear/add/shift of the

---
 rtl/multiplier_control_taint_bitwise.sv | 114 +++++++++++
 tb/tb_multiplier_control_taint_bitwise.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_control_taint_bitwise.sv
// Sequencing FSM for a shift-add multiplier with optional signed mode.
// Tracks one taint bit for its own state, fed by start and the tested multiplier bit.
module multiplier_control_taint_bitwise #(
    parameter int unsigned WIDTH        = 4,
    parameter bit          SIGNED       = 1'b0,
    parameter bit          KILL_ON_IDLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic [WIDTH-1:0] multiplierReg_t,
    output logic             busy,
    output logic             productDone,
    output logic             rsload,
    output logic             rssub,
    output logic             rsclear,
    output logic             rsshr,
    output logic             mrld,
    output logic             mdld,
    output logic             busy_t,
    output logic             productDone_t,
    output logic             rsload_t,
    output logic             rssub_t,
    output logic             rsclear_t,
    output logic             rsshr_t,
    output logic             mrld_t,
    output logic             mdld_t
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StTest, StAdd, StShift, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          taint_q, taint_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            taint_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            taint_q <= taint_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        taint_d     = taint_q;
        productDone = 1'b0;
        rsload      = 1'b0;
        rssub       = 1'b0;
        rsclear     = 1'b0;
        rsshr       = 1'b0;
        mrld        = 1'b0;
        mdld        = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                taint_d = taint_q | start_t;
                if (start) state_d = StLoad;
            end
            StLoad: begin
                mrld    = 1'b1;
                mdld    = 1'b1;
                rsclear = 1'b1;
                state_d = StTest;
            end
            StTest: begin
                // Branch depends on the tested bit only, so only its taint propagates.
                taint_d = taint_q | multiplierReg_t[cnt_q];
                state_d = multiplierReg[cnt_q] ? StAdd : StShift;
            end
            StAdd: begin
                rsload  = 1'b1;
                rssub   = SIGNED && (cnt_q == CntMax);
                state_d = StShift;
            end
            StShift: begin
                rsshr = 1'b1;
                if (cnt_q == CntMax) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = StTest;
                end
            end
            StDone: begin
                productDone = 1'b1;
                if (KILL_ON_IDLE) taint_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy          = (state_q != StIdle);
    assign busy_t        = taint_q;
    assign productDone_t = taint_q;
    assign rsload_t      = taint_q;
    assign rssub_t       = taint_q;
    assign rsclear_t     = taint_q;
    assign rsshr_t       = taint_q;
    assign mrld_t        = taint_q;
    assign mdld_t        = taint_q;

endmodule

// File: tb/tb_multiplier_control_taint_bitwise.sv
// Directed bench: three controller instances (default, sticky taint, signed) share inputs.
module tb_multiplier_control_taint_bitwise;

    // Output vector order: busy, productDone, rsload, rssub, rsclear, rsshr, mrld, mdld
    localparam logic [7:0] OI = 8'b0000_0000;
    localparam logic [7:0] OL = 8'b1000_1011;
    localparam logic [7:0] OT = 8'b1000_0000;
    localparam logic [7:0] OA = 8'b1010_0000;
    localparam logic [7:0] OS = 8'b1011_0000;
    localparam logic [7:0] OH = 8'b1000_0100;
    localparam logic [7:0] OD = 8'b1100_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start_t;
    logic [3:0] mult;
    logic [3:0] mult_t;
    wire  [7:0] o0, t0, o1, t1, o2, t2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multiplier_control_taint_bitwise #(.WIDTH(4), .SIGNED(1'b0), .KILL_ON_IDLE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .start_t(start_t),
        .multiplierReg(mult), .multiplierReg_t(mult_t),
        .busy(o0[7]), .productDone(o0[6]), .rsload(o0[5]), .rssub(o0[4]),
        .rsclear(o0[3]), .rsshr(o0[2]), .mrld(o0[1]), .mdld(o0[0]),
        .busy_t(t0[7]), .productDone_t(t0[6]), .rsload_t(t0[5]), .rssub_t(t0[4]),
        .rsclear_t(t0[3]), .rsshr_t(t0[2]), .mrld_t(t0[1]), .mdld_t(t0[0])
    );

    multiplier_control_taint_bitwise #(.WIDTH(4), .SIGNED(1'b0), .KILL_ON_IDLE(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .start_t(start_t),
        .multiplierReg(mult), .multiplierReg_t(mult_t),
        .busy(o1[7]), .productDone(o1[6]), .rsload(o1[5]), .rssub(o1[4]),
        .rsclear(o1[3]), .rsshr(o1[2]), .mrld(o1[1]), .mdld(o1[0]),
        .busy_t(t1[7]), .productDone_t(t1[6]), .rsload_t(t1[5]), .rssub_t(t1[4]),
        .rsclear_t(t1[3]), .rsshr_t(t1[2]), .mrld_t(t1[1]), .mdld_t(t1[0])
    );

    multiplier_control_taint_bitwise #(.WIDTH(4), .SIGNED(1'b1), .KILL_ON_IDLE(1'b1)) dut2 (
        .clk(clk), .rst(rst), .start(start), .start_t(start_t),
        .multiplierReg(mult), .multiplierReg_t(mult_t),
        .busy(o2[7]), .productDone(o2[6]), .rsload(o2[5]), .rssub(o2[4]),
        .rsclear(o2[3]), .rsshr(o2[2]), .mrld(o2[1]), .mdld(o2[0]),
        .busy_t(t2[7]), .productDone_t(t2[6]), .rsload_t(t2[5]), .rssub_t(t2[4]),
        .rsclear_t(t2[3]), .rsshr_t(t2[2]), .mrld_t(t2[1]), .mdld_t(t2[0])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        start   = 1'b0;
        start_t = 1'b0;
        mult    = 4'b0000;
        mult_t  = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    // Raises start for exactly one edge (E0); returns sampled just after E0.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b1;
        start_t = 1'b1;
        mult    = 4'b1111;
        mult_t  = 4'b1111;
        #1;
        n_tests++;
        if ({o0, t0, o1, t1, o2, t2} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_async got %h want 0", {o0, t0, o1, t1, o2, t2});
        end
        tick();
        n_tests++;
        if ({o0, t0, o1, t1, o2, t2} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_held got %h want 0", {o0, t0, o1, t1, o2, t2});
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [7:0] seq [14];
        logic [7:0] sgn [14];
        seq = '{OL, OT, OA, OH, OT, OA, OH, OT, OH, OT, OA, OH, OD, OI};
        sgn = '{OL, OT, OA, OH, OT, OA, OH, OT, OH, OT, OS, OH, OD, OI};
        do_reset();
        mult = 4'b1011;
        pulse_start();
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            n_tests++;
            if (o0 !== seq[k] || t0 !== 8'h00) begin
                n_fail++;
                $display("FAIL basic_seq k=%0d got %h/%h want %h/00", k, o0, t0, seq[k]);
            end
            n_tests++;
            if (o2 !== sgn[k]) begin
                n_fail++;
                $display("FAIL signed_1011 k=%0d got %h want %h", k, o2, sgn[k]);
            end
        end
    endtask

    task automatic test_taint_kill();
        logic [7:0] seq [14];
        logic [7:0] tnt;
        seq = '{OL, OT, OA, OH, OT, OA, OH, OT, OH, OT, OA, OH, OD, OI};
        do_reset();
        mult   = 4'b1011;
        mult_t = 4'b0100;
        pulse_start();
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            tnt = (k >= 8 && k <= 12) ? 8'hFF : 8'h00;
            n_tests++;
            if (o0 !== seq[k] || t0 !== tnt) begin
                n_fail++;
                $display("FAIL taint_kill k=%0d got %h/%h want %h/%h", k, o0, t0, seq[k], tnt);
            end
        end
    endtask

    task automatic test_taint_sticky();
        logic [7:0] tnt;
        do_reset();
        mult   = 4'b1011;
        mult_t = 4'b0100;
        pulse_start();
        for (int k = 0; k < 17; k++) begin
            if (k > 0) tick();
            tnt = (k >= 8) ? 8'hFF : 8'h00;
            n_tests++;
            if (t1 !== tnt) begin
                n_fail++;
                $display("FAIL taint_sticky k=%0d got %h want %h", k, t1, tnt);
            end
        end
        n_tests++;
        if (o1 !== OI) begin
            n_fail++;
            $display("FAIL sticky_idle got %h want %h", o1, OI);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (t1 !== 8'h00) begin
            n_fail++;
            $display("FAIL sticky_rst got %h want 00", t1);
        end
        rst = 1'b0;
    endtask

    task automatic test_signed_msb();
        logic [7:0] sgn [12];
        logic [7:0] uns [12];
        sgn = '{OL, OT, OH, OT, OH, OT, OH, OT, OS, OH, OD, OI};
        uns = '{OL, OT, OH, OT, OH, OT, OH, OT, OA, OH, OD, OI};
        do_reset();
        mult = 4'b1000;
        pulse_start();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            n_tests++;
            if (o2 !== sgn[k] || o0 !== uns[k]) begin
                n_fail++;
                $display("FAIL signed_msb k=%0d got %h/%h want %h/%h", k, o2, o0, sgn[k], uns[k]);
            end
        end
    endtask

    task automatic test_start_taint();
        logic [7:0] seq [11];
        logic [7:0] tnt;
        seq = '{OL, OT, OH, OT, OH, OT, OH, OT, OH, OD, OI};
        do_reset();
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        tick();
        tick();
        n_tests++;
        if (o0 !== OI || t0 !== 8'hFF) begin
            n_fail++;
            $display("FAIL start_t_idle got %h/%h want %h/ff", o0, t0, OI);
        end
        mult = 4'b0000;
        pulse_start();
        for (int k = 0; k < 11; k++) begin
            if (k > 0) tick();
            tnt = (k < 10) ? 8'hFF : 8'h00;
            n_tests++;
            if (o0 !== seq[k] || t0 !== tnt) begin
                n_fail++;
                $display("FAIL start_t_job k=%0d got %h/%h want %h/%h", k, o0, t0, seq[k], tnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mult   = 4'b1011;
        mult_t = 4'b0001;
        pulse_start();
        tick();
        tick();
        n_tests++;
        if (o0 !== OA || t0 !== 8'hFF) begin
            n_fail++;
            $display("FAIL mid_add got %h/%h want %h/ff", o0, t0, OA);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (o0 !== 8'h00 || t0 !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_rst got %h/%h want 00/00", o0, t0);
        end
        tick();
        rst    = 1'b0;
        mult_t = 4'b0000;
        pulse_start();
        for (int k = 1; k <= 13; k++) begin
            tick();
            n_tests++;
            if (o0[6] !== (k == 12) || t0 !== 8'h00) begin
                n_fail++;
                $display("FAIL mid_rerun k=%0d got done=%b t=%h want done=%b t=00",
                         k, o0[6], t0, (k == 12));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [14];
        seq = '{OL, OT, OH, OT, OH, OT, OH, OT, OH, OD, OI, OL, OT, OH};
        do_reset();
        mult  = 4'b0000;
        start = 1'b1;
        tick();
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            n_tests++;
            if (o0 !== seq[k]) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d got %h want %h", k, o0, seq[k]);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_taint_kill();
        test_taint_sticky();
        test_signed_msb();
        test_start_taint();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
